// File: rtl/bus_pkg.sv
// Shared bus definitions: ID field width, broadcast ID and packet field helpers.
package bus_pkg;

    localparam int ID_W      = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
    // Widest packet the helpers handle; callers zero-extend into this width.
    localparam int PKT_MAX_W = 64;

    // Destination ID sits in the top ID_W bits of an sz-bit packet.
    function automatic logic [ID_W-1:0] get_id(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned sz);
        logic [PKT_MAX_W-1:0] sh;
        sh = pkt >> (sz - ID_W);
        return sh[ID_W-1:0];
    endfunction

    function automatic logic [PKT_MAX_W-1:0] get_payload(input logic [PKT_MAX_W-1:0] pkt,
                                                         input int unsigned sz);
        logic [PKT_MAX_W-1:0] mask;
        mask = (PKT_MAX_W'(1) << (sz - ID_W)) - PKT_MAX_W'(1);
        return pkt & mask;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port; depth must be a power of 2.
module sync_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth) + 1;

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same edge, so a full FIFO can still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(depth));
    assign empty = (count == '0);

endmodule

// File: rtl/bus_rx_node.sv
// Bus receive node: filters packets by destination ID into a FIFO, counts overflow
// drops and flags out-of-range IDs. Define BUS_RX_BROADCAST_EN to also accept BCAST_ID.
module bus_rx_node
    import bus_pkg::*;
#(
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int my_id   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               pop,
    output logic [pckg_sz-1:0] D_pop,
    output logic               pndng,
    output logic               full,
    output logic [15:0]        drop_cnt,
    output logic               id_err
);

    localparam logic [ID_W-1:0] MY_ID    = ID_W'(my_id);
    localparam logic [ID_W-1:0] DRVRS_ID = ID_W'(drvrs);

    logic [ID_W-1:0] pkt_id;
    logic            is_bcast;
    logic            id_match;
    logic            id_bad;
    logic            fifo_empty;
    logic            drop_now;

    function automatic logic [15:0] sat_inc16(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    assign pkt_id = get_id(PKT_MAX_W'(D_push), pckg_sz);

`ifdef BUS_RX_BROADCAST_EN
    assign is_bcast = (pkt_id == BCAST_ID);
`else
    assign is_bcast = 1'b0;
`endif

    assign id_match = (pkt_id == MY_ID) || is_bcast;
    assign id_bad   = (pkt_id >= DRVRS_ID) && !is_bcast;
    // Only a matching packet that finds no room (and no simultaneous pop) is lost.
    assign drop_now = push && id_match && full && !pop;

    sync_fifo #(
        .width (pckg_sz),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push && id_match),
        .pop   (pop),
        .din   (D_push),
        .dout  (D_pop),
        .full  (full),
        .empty (fifo_empty)
    );

    assign pndng = !fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
            id_err   <= 1'b0;
        end else begin
            if (drop_now)      drop_cnt <= sat_inc16(drop_cnt);
            if (push && id_bad) id_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_rx_node.sv
// Directed bench for bus_rx_node (my_id=1, drvrs=4, depth=8, 16-bit packets).
module tb_bus_rx_node;

    logic        clk = 1'b0;
    logic        reset;
    logic        push;
    logic [15:0] D_push;
    logic        pop;
    logic [15:0] D_pop;
    logic        pndng;
    logic        full;
    logic [15:0] drop_cnt;
    logic        id_err;

    int n_cmp  = 0;
    int n_fail = 0;

    bus_rx_node #(
        .drvrs   (4),
        .pckg_sz (16),
        .depth   (8),
        .my_id   (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .D_push   (D_push),
        .pop      (pop),
        .D_pop    (D_pop),
        .pndng    (pndng),
        .full     (full),
        .drop_cnt (drop_cnt),
        .id_err   (id_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [15:0] data;
        logic        pop;
        logic        exp_pndng;
        logic        exp_full;
        logic        chk_dpop;
        logic [15:0] exp_dpop;
        logic [15:0] exp_drop;
        logic        exp_id_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then sample 1 ns after the edge.
    task automatic step(input logic p, input logic [15:0] d, input logic q);
        push   = p;
        D_push = d;
        pop    = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 16'h0000, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        D_push = '0;
        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        reset = 1'b1;

        chk("rst_pndng", 32'(pndng), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        chk("rst_id_err", 32'(id_err), 32'h0);

        //          push  data      pop   pndng full  chkd  dpop      drop   iderr
        vecs[0] = '{1'b1, 16'h01AB, 1'b0, 1'b1, 1'b0, 1'b1, 16'h01AB, 16'd0, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0};
        vecs[3] = '{1'b1, 16'h02CC, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0};
        vecs[4] = '{1'b1, 16'h00DA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0};
        vecs[5] = '{1'b1, 16'h0155, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0155, 16'd0, 1'b0};
        vecs[6] = '{1'b1, 16'h0166, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0155, 16'd0, 1'b0};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0166, 16'd0, 1'b0};

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].push, vecs[i].data, vecs[i].pop);
            chk($sformatf("vec%0d_pndng", i), 32'(pndng), 32'(vecs[i].exp_pndng));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            if (vecs[i].chk_dpop)
                chk($sformatf("vec%0d_dpop", i), 32'(D_pop), 32'(vecs[i].exp_dpop));
            chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(vecs[i].exp_drop));
            chk($sformatf("vec%0d_id_err", i), 32'(id_err), 32'(vecs[i].exp_id_err));
        end
        step(1'b0, 16'h0000, 1'b1);
        chk("drain_pndng", 32'(pndng), 32'h0);

        // Overflow: nine matching pushes into an 8-deep FIFO, last one dropped.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 1'b0);
            if (i == 6) chk("fill7_full", 32'(full), 32'h0);
        end
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_drop", 32'(drop_cnt), 32'h1);
        chk("ovf_head", 32'(D_pop), 32'h0100);

        // Push and pop together while full: nothing lost, still full.
        step(1'b1, 16'h01EE, 1'b1);
        chk("pp_full", 32'(full), 32'h1);
        chk("pp_drop", 32'(drop_cnt), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pop%0d_pndng", i), 32'(pndng), 32'h1);
            chk($sformatf("pop%0d_data", i), 32'(D_pop),
                (i == 7) ? 32'h01EE : 32'h0101 + 32'(i));
            step(1'b0, 16'h0000, 1'b1);
        end
        chk("popall_pndng", 32'(pndng), 32'h0);
        chk("popall_full", 32'(full), 32'h0);

        // Broadcast ID and out-of-range ID handling.
        do_reset();
        chk("rst2_drop", 32'(drop_cnt), 32'h0);
        step(1'b1, 16'hFF22, 1'b0);
`ifdef BUS_RX_BROADCAST_EN
        chk("bcast_pndng", 32'(pndng), 32'h1);
        chk("bcast_dpop", 32'(D_pop), 32'hFF22);
        chk("bcast_id_err", 32'(id_err), 32'h0);
        step(1'b0, 16'h0000, 1'b1);
`else
        chk("bcast_pndng", 32'(pndng), 32'h0);
        chk("bcast_id_err", 32'(id_err), 32'h1);
        do_reset();
        chk("rst3_id_err", 32'(id_err), 32'h0);
`endif
        step(1'b1, 16'h0711, 1'b0);
        chk("bad_id_err", 32'(id_err), 32'h1);
        chk("bad_pndng", 32'(pndng), 32'h0);
        chk("bad_drop", 32'(drop_cnt), 32'h0);
        step(1'b1, 16'h0312, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        chk("sticky_id_err", 32'(id_err), 32'h1);
        chk("legal_other_pndng", 32'(pndng), 32'h0);

        // Mid-operation reset with three entries queued and a nonzero drop count.
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0140 + 16'(i), 1'b0);
        step(1'b1, 16'h01F0, 1'b0);
        chk("pre_rst_drop", 32'(drop_cnt), 32'h1);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b1);
        chk("pre_rst_head", 32'(D_pop), 32'h0145);
        reset = 1'b0;
        step(1'b1, 16'h01AA, 1'b1);
        reset = 1'b1;
        chk("midrst_pndng", 32'(pndng), 32'h0);
        chk("midrst_full", 32'(full), 32'h0);
        chk("midrst_drop", 32'(drop_cnt), 32'h0);
        chk("midrst_id_err", 32'(id_err), 32'h0);
        step(1'b1, 16'h0133, 1'b0);
        chk("post_rst_pndng", 32'(pndng), 32'h1);
        chk("post_rst_dpop", 32'(D_pop), 32'h0133);
        step(1'b0, 16'h0000, 1'b1);
        chk("post_rst_empty", 32'(pndng), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
